// File: rtl/piso_serializer_fifo.sv
// piso_serializer_fifo
//   Parallel-in / serial-out serializer with a small input FIFO. Words come in
//   over a valid/ready handshake and leave LANE_WIDTH bits per cycle, LSB- or
//   MSB-first, optionally followed by one even-parity beat. Back-to-back words
//   stream with no idle cycle between them.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   data_in      word to transmit
//   valid_in     producer offers data_in
//   ready_in     FIFO has room; push happens on valid_in && ready_in
//   msb_first    bit order, sampled when a word loads into the shifter
//   data_out     current serial beat
//   valid_out    data_out carries a valid beat
//   last_out     final beat of the current word (parity beat when enabled)
//   busy         shifter active or FIFO non-empty
//   fifo_count   words currently held in the FIFO
//
// FSM states
//   state    | meaning
//   S_IDLE   | nothing on the link; waits for a FIFO word
//   S_SHIFT  | presenting data beat r_beat_cnt of the loaded word
//   S_PARITY | presenting the even-parity beat of the loaded word

module piso_serializer_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic                          msb_first,
    output logic [LANE_WIDTH-1:0]         data_out,
    output logic                          valid_out,
    output logic                          last_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BEATS = DATA_WIDTH / LANE_WIDTH;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CNTW  = PW + 1;

    localparam logic [CW-1:0]   LAST_BEAT = CW'(BEATS - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);
    localparam bit              NO_PAR    = (PARITY_EN == 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CNTW-1:0]       r_count;
    logic                  r_ready;

    // Shifter / FSM
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_beat_cnt;
    logic                  r_msb;
    logic                  r_parity;
    logic [LANE_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_last_out;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_nonempty;
    logic [DATA_WIDTH-1:0] w_head;
    logic [CNTW-1:0]       w_count_nxt;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_msb_nxt;
    logic                  w_parity_nxt;
    logic [LANE_WIDTH-1:0] w_data_nxt;
    logic                  w_valid_nxt;
    logic                  w_last_nxt;
    logic [LANE_WIDTH-1:0] w_par_beat;

    // ready_in is a register rather than decoded from r_count so that it stays
    // low for the first cycle after reset release, as the producer expects.
    assign w_push     = valid_in && r_ready;
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_pop      = w_load;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_par_beat    = '0;
        w_par_beat[0] = r_parity;
    end

    // Next-beat logic: the outputs are registered, so this process decides what
    // the link shows in the cycle after the coming edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_beat_cnt;
        w_msb_nxt    = r_msb;
        w_parity_nxt = r_parity;
        w_data_nxt   = '0;
        w_valid_nxt  = 1'b0;
        w_last_nxt   = 1'b0;
        w_load       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_beat_cnt == LAST_BEAT) begin
                    if (!NO_PAR) begin
                        w_state_nxt = S_PARITY;
                        w_data_nxt  = w_par_beat;
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = 1'b1;
                    end else if (w_nonempty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt   = r_beat_cnt + 1'b1;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = NO_PAR && (w_cnt_nxt == LAST_BEAT);
                    if (r_msb) begin
                        w_data_nxt  = r_shift[DATA_WIDTH-1 -: LANE_WIDTH];
                        w_shift_nxt = r_shift << LANE_WIDTH;
                    end else begin
                        w_data_nxt  = r_shift[LANE_WIDTH-1:0];
                        w_shift_nxt = r_shift >> LANE_WIDTH;
                    end
                end
            end
            S_PARITY: begin
                if (w_nonempty) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Loading presents beat 0 immediately, which is what gives zero-gap
        // streaming between words. Parity is taken from the unshifted word.
        if (w_load) begin
            w_state_nxt  = S_SHIFT;
            w_cnt_nxt    = '0;
            w_msb_nxt    = msb_first;
            w_parity_nxt = ^w_head;
            w_valid_nxt  = 1'b1;
            w_last_nxt   = NO_PAR && (LAST_BEAT == '0);
            if (msb_first) begin
                w_data_nxt  = w_head[DATA_WIDTH-1 -: LANE_WIDTH];
                w_shift_nxt = w_head << LANE_WIDTH;
            end else begin
                w_data_nxt  = w_head[LANE_WIDTH-1:0];
                w_shift_nxt = w_head >> LANE_WIDTH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ready     <= 1'b0;
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_beat_cnt  <= '0;
            r_msb       <= 1'b0;
            r_parity    <= 1'b0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_nxt;
            r_ready     <= (w_count_nxt != FULL_CNT);
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_beat_cnt  <= w_cnt_nxt;
            r_msb       <= w_msb_nxt;
            r_parity    <= w_parity_nxt;
            r_data_out  <= w_data_nxt;
            r_valid_out <= w_valid_nxt;
            r_last_out  <= w_last_nxt;
        end
    end

    assign ready_in   = r_ready;
    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign last_out   = r_last_out;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);
    assign fifo_count = r_count;

endmodule

// File: tb/tb_piso_serializer_fifo.sv
// Testbench for piso_serializer_fifo. Three instances share clk/rst:
//   u_dut0 : 8-bit word, 1-bit lane, no parity
//   u_dut1 : 8-bit word, 2-bit lane, no parity
//   u_dut2 : 8-bit word, 1-bit lane, parity beat enabled
// A negedge monitor records every valid beat into shared queues; only one
// instance is driven at a time.

module tb_piso_serializer_fifo;

    logic clk;
    logic rst;

    logic [7:0] din0, din1, din2;
    logic       vin0, vin1, vin2;
    logic       msb0, msb1, msb2;
    logic       rdy0, rdy1, rdy2;
    logic [0:0] dout0;
    logic [1:0] dout1;
    logic [0:0] dout2;
    logic       vout0, vout1, vout2;
    logic       lout0, lout1, lout2;
    logic       busy0, busy1, busy2;
    logic [2:0] cnt0, cnt1, cnt2;

    int n_chk;
    int n_err;
    int cyc;
    int push_cyc;
    int idle_cyc;

    int q_data[$];
    int q_last[$];
    int q_cyc[$];
    int exp_d[$];
    int exp_l[$];

    piso_serializer_fifo #(.DATA_WIDTH(8), .LANE_WIDTH(1), .FIFO_DEPTH(4), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(din0), .valid_in(vin0), .ready_in(rdy0),
        .msb_first(msb0), .data_out(dout0), .valid_out(vout0), .last_out(lout0),
        .busy(busy0), .fifo_count(cnt0)
    );

    piso_serializer_fifo #(.DATA_WIDTH(8), .LANE_WIDTH(2), .FIFO_DEPTH(4), .PARITY_EN(0)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(din1), .valid_in(vin1), .ready_in(rdy1),
        .msb_first(msb1), .data_out(dout1), .valid_out(vout1), .last_out(lout1),
        .busy(busy1), .fifo_count(cnt1)
    );

    piso_serializer_fifo #(.DATA_WIDTH(8), .LANE_WIDTH(1), .FIFO_DEPTH(4), .PARITY_EN(1)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(din2), .valid_in(vin2), .ready_in(rdy2),
        .msb_first(msb2), .data_out(dout2), .valid_out(vout2), .last_out(lout2),
        .busy(busy2), .fifo_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vout0) begin
            q_data.push_back(int'(dout0));
            q_last.push_back(int'(lout0));
            q_cyc.push_back(cyc);
        end
        if (vout1) begin
            q_data.push_back(int'(dout1));
            q_last.push_back(int'(lout1));
            q_cyc.push_back(cyc);
        end
        if (vout2) begin
            q_data.push_back(int'(dout2));
            q_last.push_back(int'(lout2));
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic get_rdy(input int inst);
        case (inst)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        case (inst)
            0:       return busy0 | vout0;
            1:       return busy1 | vout1;
            default: return busy2 | vout2;
        endcase
    endfunction

    task automatic set_in(input int inst, input logic [7:0] d, input logic v);
        case (inst)
            0:       begin din0 = d; vin0 = v; end
            1:       begin din1 = d; vin1 = v; end
            default: begin din2 = d; vin2 = v; end
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int inst, input logic [7:0] d);
        set_in(inst, d, 1'b1);
        for (int t = 0; t < 400; t++) begin
            if (get_rdy(inst)) begin
                @(negedge clk);
                set_in(inst, 8'h00, 1'b0);
                push_cyc = cyc;
                return;
            end
            @(negedge clk);
        end
        chk("push_ready_timeout", int'(get_rdy(inst)), 1);
        set_in(inst, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input int inst);
        for (int t = 0; t < 1000; t++) begin
            if (!get_busy(inst)) begin
                idle_cyc = cyc;
                return;
            end
            @(negedge clk);
        end
        chk("idle_timeout", int'(get_busy(inst)), 0);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    // Compares the captured beats against exp_d/exp_l and checks that they
    // occupy consecutive cycles.
    task automatic check_seq(input string tag);
        chk({tag, "_nbeats"}, q_data.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < q_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), q_data[i], exp_d[i]);
            chk($sformatf("%s_last%0d", tag, i), q_last[i], exp_l[i]);
            if (i > 0) chk($sformatf("%s_gap%0d", tag, i), q_cyc[i], q_cyc[i-1] + 1);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        msb0 = 1'b0; msb1 = 1'b0; msb2 = 1'b0;
        set_in(0, 8'h00, 1'b0);
        set_in(1, 8'h00, 1'b0);
        set_in(2, 8'h00, 1'b0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid0", int'(vout0), 0);
        chk("rst_last0",  int'(lout0), 0);
        chk("rst_data0",  int'(dout0), 0);
        chk("rst_busy0",  int'(busy0), 0);
        chk("rst_ready0", int'(rdy0),  0);
        chk("rst_cnt0",   int'(cnt0),  0);
        chk("rst_cnt1",   int'(cnt1),  0);
        chk("rst_cnt2",   int'(cnt2),  0);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", int'(rdy0), 0);
        @(negedge clk);
        chk("ready_after_edge", int'(rdy0), 1);

        // 1: LSB-first 0x73
        clear_q();
        msb0 = 1'b0;
        push(0, 8'h73);
        wait_idle(0);
        exp_d = '{1, 1, 0, 0, 1, 1, 1, 0};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 1};
        check_seq("lsb73");
        if (q_cyc.size() > 0) begin
            chk("lsb73_latency", q_cyc[0], push_cyc + 1);
            chk("lsb73_busy_fall", idle_cyc, q_cyc[q_cyc.size()-1] + 1);
        end

        // 2: MSB-first 0x1F
        clear_q();
        msb0 = 1'b1;
        push(0, 8'h1F);
        wait_idle(0);
        exp_d = '{0, 0, 0, 1, 1, 1, 1, 1};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 1};
        check_seq("msb1f");

        // 3: back-to-back words, no gap
        clear_q();
        msb0 = 1'b0;
        push(0, 8'h73);
        push(0, 8'h1F);
        wait_idle(0);
        exp_d = '{1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        check_seq("b2b");

        // 4: FIFO fill and backpressure, 7 words in order
        clear_q();
        msb0 = 1'b0;
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        push(0, 8'h44);
        push(0, 8'h55);
        chk("full_cnt",   int'(cnt0), 4);
        chk("full_ready", int'(rdy0), 0);
        push(0, 8'h66);
        chk("refill_cnt", int'(cnt0), 4);
        push(0, 8'h77);
        wait_idle(0);
        chk("fill_nbeats", q_data.size(), 56);
        for (int w = 0; w < 7; w++) begin
            int word;
            word = 0;
            for (int b = 0; b < 8 && (w*8 + b) < q_data.size(); b++) begin
                word = word | (q_data[w*8 + b] << b);
            end
            chk($sformatf("fill_word%0d", w), word, (w + 1) * 8'h11);
        end
        if (q_cyc.size() == 56) chk("fill_contiguous", q_cyc[55], q_cyc[0] + 55);

        // 5a: 2-bit lane, LSB-first 0xB4
        clear_q();
        msb1 = 1'b0;
        push(1, 8'hB4);
        wait_idle(1);
        exp_d = '{0, 1, 3, 2};
        exp_l = '{0, 0, 0, 1};
        check_seq("lane2_b4");

        // 5b: parity beat, odd and even population
        clear_q();
        msb2 = 1'b0;
        push(2, 8'h73);
        wait_idle(2);
        exp_d = '{1, 1, 0, 0, 1, 1, 1, 0, 1};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        check_seq("par73");

        clear_q();
        push(2, 8'h33);
        wait_idle(2);
        exp_d = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        check_seq("par33");

        // 6: reset mid-word with two words queued
        clear_q();
        msb0 = 1'b0;
        push(0, 8'h73);
        push(0, 8'hAA);
        push(0, 8'h55);
        chk("pre_rst_cnt", int'(cnt0), 2);
        @(negedge clk);
        chk("pre_rst_valid", int'(vout0), 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(vout0), 0);
        chk("midrst_last",  int'(lout0), 0);
        chk("midrst_data",  int'(dout0), 0);
        chk("midrst_busy",  int'(busy0), 0);
        chk("midrst_cnt",   int'(cnt0),  0);
        chk("midrst_ready", int'(rdy0),  0);
        clear_q();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_ready", int'(rdy0), 1);
        for (int t = 0; t < 20; t++) @(negedge clk);
        chk("postrst_quiet", q_data.size(), 0);
        chk("postrst_cnt", int'(cnt0), 0);

        clear_q();
        push(0, 8'h5A);
        wait_idle(0);
        exp_d = '{0, 1, 0, 1, 1, 0, 1, 0};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 1};
        check_seq("postrst5a");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_serializer_fifo.md
Name: piso_serializer_fifo

Overview:
- Parametrised parallel-in/serial-out serializer; successor to the single-word PISO.
- Accepts DATA_WIDTH-bit words over a valid/ready handshake into a small input FIFO.
- Emits each word LANE_WIDTH bits per cycle, LSB-first or MSB-first, with an optional even-parity beat.
- Sits between a word-oriented producer and a narrow serial link. Back-to-back words stream without bubbles.

Parameters:
DATA_WIDTH, 8, word width; must be a multiple of LANE_WIDTH.
LANE_WIDTH, 1, bits emitted per output beat.
FIFO_DEPTH, 4, input FIFO entries; power of 2, >=2.
PARITY_EN, 0, 1 = append an even-parity beat after each word's data beats.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
data_in  in  DATA_WIDTH  word to transmit.
valid_in  in  1  producer offers data_in.
ready_in  out  1  FIFO can accept; push occurs when valid_in && ready_in.
msb_first  in  1  bit order, sampled when a word loads into the shifter.
data_out  out  LANE_WIDTH  current serial beat.
valid_out  out  1  data_out is a valid beat.
last_out  out  1  final beat of the current word (the parity beat if PARITY_EN).
busy  out  1  shifter active or FIFO non-empty.
fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO.

Behaviour:
- Reset: all outputs go to 0 immediately on rst. Exception: ready_in returns to 1 on the first clk edge after rst deasserts. FIFO pointers clear; FSM goes to IDLE.
- Reset mid-word: the word in flight and all FIFO contents are discarded. No partial beats follow reset.
- BEATS = DATA_WIDTH/LANE_WIDTH. Beat counter width is $clog2(BEATS+1).
- FIFO:
  - ready_in = (fifo_count != FIFO_DEPTH). It is purely from registered count; no same-cycle pop credit.
  - A push and pop in the same cycle leaves the count unchanged.
- FSM states:
  - IDLE: valid_out=0, data_out=0. If FIFO non-empty at an edge: pop the head word, latch msb_first, go to SHIFT, beat_cnt=0.
  - SHIFT: each cycle valid_out=1.
    - LSB-first: data_out = word[LANE_WIDTH-1:0], then shift right by LANE_WIDTH.
    - MSB-first: data_out = word[DATA_WIDTH-1 -: LANE_WIDTH], then shift left.
    - On beat BEATS-1:
      - If PARITY_EN: go to PARITY.
      - Else: last_out=1. If FIFO non-empty, pop and reload in the same edge, staying in SHIFT (zero-gap). Otherwise go to IDLE.
  - PARITY: one beat. data_out[0] = XOR of all DATA_WIDTH bits; other lanes 0. valid_out=1, last_out=1. Then reload (if FIFO non-empty) or go to IDLE, exactly as above.
- Parity is computed on the word as loaded, not on the shifted register.
- Latency: word pushed at edge N into an empty FIFO with FSM in IDLE → first beat valid in the cycle after edge N+1.
- No output backpressure: once started, a word always completes in BEATS (+1) consecutive cycles.
- msb_first changes mid-word have no effect on the word in flight.
- busy = (state != IDLE) || (fifo_count != 0).
- Outputs are registered; valid_out, last_out and data_out are mutually cycle-aligned.

Test Plan:
1. DATA_WIDTH=8, LANE_WIDTH=1, msb_first=0, push 0x73 → data_out 1,1,0,0,1,1,1,0 on 8 consecutive valid_out cycles; last_out on the 8th only; busy falls after it.
2. Same config, msb_first=1, push 0x1F → data_out 0,0,0,1,1,1,1,1.
3. Push 0x73 then 0x1F on consecutive cycles → 16 contiguous valid_out cycles with no gap; last_out on beats 8 and 16.
4. FIFO_DEPTH=4, hold valid_in for 7 cycles with the shifter busy → first word enters the shifter; ready_in drops after 5 accepted words (fifo_count=4); words 6-7 stall until a pop; all 7 words emerge in order.
5. LANE_WIDTH=2, LSB-first, push 0xB4 → beats 2'b00, 2'b01, 2'b11, 2'b10. PARITY_EN=1, LANE_WIDTH=1, push 0x73 → 9 beats, 9th beat data_out=1 with last_out=1.
6. Assert rst during beat 3 of 0x73 with 2 words queued → all outputs 0 immediately; fifo_count=0; no further valid_out until new pushes.
